// File: rtl/controlador_ga_pkg.sv
// Shared definitions for the GA controller: state encoding and default timing constants.
package controlador_ga_pkg;

  localparam logic [2:0] ST_OCIOSO    = 3'd0;
  localparam logic [2:0] ST_FONTE     = 3'd1;
  localparam logic [2:0] ST_GUARDA    = 3'd2;
  localparam logic [2:0] ST_ESP_READY = 3'd3;
  localparam logic [2:0] ST_ESP_LIVRE = 3'd4;
  localparam logic [2:0] ST_PRONTO    = 3'd5;
  localparam logic [2:0] ST_ERRO      = 3'd6;

  typedef enum logic [2:0] {
    OCIOSO    = ST_OCIOSO,
    FONTE     = ST_FONTE,
    GUARDA    = ST_GUARDA,
    ESP_READY = ST_ESP_READY,
    ESP_LIVRE = ST_ESP_LIVRE,
    PRONTO    = ST_PRONTO,
    ERRO      = ST_ERRO
  } estado_t;

  localparam int GUARD_CYCLES_DEF = 2;
  localparam int TIMEOUT_MAX_DEF  = 200;

endpackage

// File: rtl/controlador_ga_temporizador_espera.sv
// Loadable wait counter: flags the end of the guard window and the wait-timeout limit.
module temporizador_espera
  import controlador_ga_pkg::*;
#(
  parameter int GUARD_CYCLES = GUARD_CYCLES_DEF,
  parameter int TIMEOUT_MAX  = TIMEOUT_MAX_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic limpar,
  input  logic contar,
  output logic guarda_ok,
  output logic estourou
);

  localparam int TW = ($clog2(TIMEOUT_MAX + 1) > 8) ? $clog2(TIMEOUT_MAX + 1) : 8;

  logic [TW-1:0] cont_r;

  // Cycle counter; clearing wins over counting and it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cont_r <= {TW{1'b0}};
    end else if (limpar) begin
      cont_r <= {TW{1'b0}};
    end else if (contar && (cont_r != {TW{1'b1}})) begin
      cont_r <= cont_r + {{(TW-1){1'b0}}, 1'b1};
    end
  end

  assign guarda_ok = (cont_r >= TW'(GUARD_CYCLES - 1));
  assign estourou  = (cont_r >= TW'(TIMEOUT_MAX - 1));

endmodule

// File: rtl/controlador_ga.sv
// Sequencer/arbiter in front of the GA: one-shot source load, then serialised
// deactivation/update commands with a guard window and a sticky wait timeout.
module controlador_ga
  import controlador_ga_pkg::*;
#(
  parameter int ADDR_WIDTH   = 5,
  parameter int GUARD_CYCLES = GUARD_CYCLES_DEF,
  parameter int TIMEOUT_MAX  = TIMEOUT_MAX_DEF,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic [ADDR_WIDTH-1:0]  fonte_endereco_i,
  input  logic                   clear_erro_i,
  input  logic                   lvv_desativar_req_i,
  input  logic                   lvv_atualizar_req_i,
  output logic                   lvv_desativar_ack_o,
  output logic                   lvv_atualizar_ack_o,
  input  logic                   ga_ocupado_i,
  input  logic                   ga_atualizar_ready_i,
  output logic                   top_atualizar_fonte_o,
  output logic [ADDR_WIDTH-1:0]  top_endereco_fonte_o,
  output logic                   desativar_o,
  output logic                   atualizar_o,
  output logic                   ctrl_ocupado_o,
  output logic                   erro_timeout_o,
  output logic [COUNT_WIDTH-1:0] contador_atualizacoes_o
);

  estado_t estado_r;
  logic    fonte_carregada_r;
  logic    eh_atualizacao_r;
  logic    ready_visto_r;
  logic    limpar_s;
  logic    contar_s;
  logic    guarda_ok_s;
  logic    estourou_s;

  // Timer restarts on every command issue and again when the guard window closes.
  assign limpar_s = (estado_r == FONTE) || (estado_r == PRONTO) ||
                    ((estado_r == GUARDA) && guarda_ok_s);
  assign contar_s = (estado_r == GUARDA) || (estado_r == ESP_READY) ||
                    (estado_r == ESP_LIVRE);

  temporizador_espera #(
    .GUARD_CYCLES (GUARD_CYCLES),
    .TIMEOUT_MAX  (TIMEOUT_MAX)
  ) u_temporizador (
    .clk       (clk),
    .rst_n     (rst_n),
    .limpar    (limpar_s),
    .contar    (contar_s),
    .guarda_ok (guarda_ok_s),
    .estourou  (estourou_s)
  );

  // Main FSM; every output is set on the edge that enters the state it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_r                <= OCIOSO;
      fonte_carregada_r       <= 1'b0;
      eh_atualizacao_r        <= 1'b0;
      ready_visto_r           <= 1'b0;
      lvv_desativar_ack_o     <= 1'b0;
      lvv_atualizar_ack_o     <= 1'b0;
      top_atualizar_fonte_o   <= 1'b0;
      top_endereco_fonte_o    <= {ADDR_WIDTH{1'b0}};
      desativar_o             <= 1'b0;
      atualizar_o             <= 1'b0;
      ctrl_ocupado_o          <= 1'b0;
      erro_timeout_o          <= 1'b0;
      contador_atualizacoes_o <= {COUNT_WIDTH{1'b0}};
    end else begin
      lvv_desativar_ack_o   <= 1'b0;
      lvv_atualizar_ack_o   <= 1'b0;
      top_atualizar_fonte_o <= 1'b0;
      desativar_o           <= 1'b0;
      atualizar_o           <= 1'b0;
      case (estado_r)
        OCIOSO: begin
          if (start_i) begin
            top_endereco_fonte_o  <= fonte_endereco_i;
            top_atualizar_fonte_o <= 1'b1;
            ctrl_ocupado_o        <= 1'b1;
            estado_r              <= FONTE;
          end
        end
        FONTE: begin
          fonte_carregada_r <= 1'b1;
          eh_atualizacao_r  <= 1'b0;
          ready_visto_r     <= 1'b0;
          estado_r          <= GUARDA;
        end
        PRONTO: begin
          if (start_i) begin
            top_endereco_fonte_o  <= fonte_endereco_i;
            top_atualizar_fonte_o <= 1'b1;
            ctrl_ocupado_o        <= 1'b1;
            estado_r              <= FONTE;
          end else if (lvv_desativar_req_i) begin
            lvv_desativar_ack_o <= 1'b1;
            desativar_o         <= 1'b1;
            eh_atualizacao_r    <= 1'b0;
            ready_visto_r       <= 1'b0;
            ctrl_ocupado_o      <= 1'b1;
            estado_r            <= GUARDA;
          end else if (lvv_atualizar_req_i) begin
            lvv_atualizar_ack_o <= 1'b1;
            atualizar_o         <= 1'b1;
            eh_atualizacao_r    <= 1'b1;
            ready_visto_r       <= 1'b0;
            ctrl_ocupado_o      <= 1'b1;
            estado_r            <= GUARDA;
          end
        end
        GUARDA: begin
          // A fast GA may report completion before the guard window closes.
          if (eh_atualizacao_r && ga_atualizar_ready_i) begin
            ready_visto_r <= 1'b1;
          end
          if (guarda_ok_s) begin
            estado_r <= eh_atualizacao_r ? ESP_READY : ESP_LIVRE;
          end
        end
        ESP_READY: begin
          if (ga_atualizar_ready_i || ready_visto_r) begin
            ready_visto_r <= 1'b0;
            if (contador_atualizacoes_o != {COUNT_WIDTH{1'b1}}) begin
              contador_atualizacoes_o <= contador_atualizacoes_o + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
            end
            estado_r <= ESP_LIVRE;
          end else if (estourou_s) begin
            erro_timeout_o <= 1'b1;
            estado_r       <= ERRO;
          end
        end
        ESP_LIVRE: begin
          if (!ga_ocupado_i) begin
            ctrl_ocupado_o <= 1'b0;
            estado_r       <= fonte_carregada_r ? PRONTO : OCIOSO;
          end else if (estourou_s) begin
            erro_timeout_o <= 1'b1;
            estado_r       <= ERRO;
          end
        end
        ERRO: begin
          if (clear_erro_i) begin
            erro_timeout_o    <= 1'b0;
            fonte_carregada_r <= 1'b0;
            ctrl_ocupado_o    <= 1'b0;
            estado_r          <= OCIOSO;
          end
        end
        default: begin
          ctrl_ocupado_o <= 1'b0;
          estado_r       <= OCIOSO;
        end
      endcase
    end
  end

endmodule

// File: doc/controlador_ga.md
Name: controlador_ga

Overview:
- Sequencer and arbiter in front of gerenciador_ativos (GA).
- Issues the one-shot source load, then arbitrates LVV deactivation and update requests to the GA.
- Each GA command is a single-cycle pulse. No new command is issued until the GA reports idle, so the GA never sees overlapping commands.
- Flags a sticky timeout error if the GA stays busy too long.

Parameters:
- ADDR_WIDTH, 5: node address width.
- GUARD_CYCLES, 2: cycles ignored after a command pulse before ga_ocupado_i is trusted (covers the GA's registered ocupado path). Minimum 1.
- TIMEOUT_MAX, 200: maximum cycles to wait for GA idle or ready.
- COUNT_WIDTH, 16: width of the completed-update counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- start_i  in  1  begin run: load the source node
- fonte_endereco_i  in  ADDR_WIDTH  source address, sampled on an accepted start_i
- clear_erro_i  in  1  clears ERRO and erro_timeout_o
- lvv_desativar_req_i  in  1  LVV requests deactivation (level, held until ack)
- lvv_atualizar_req_i  in  1  LVV requests update (level, held until ack)
- lvv_desativar_ack_o  out  1  one-cycle grant of a deactivation request
- lvv_atualizar_ack_o  out  1  one-cycle grant of an update request
- ga_ocupado_i  in  1  GA busy
- ga_atualizar_ready_i  in  1  GA update-completion pulse
- top_atualizar_fonte_o  out  1  source-load pulse to GA
- top_endereco_fonte_o  out  ADDR_WIDTH  registered source address
- desativar_o  out  1  deactivation pulse to GA
- atualizar_o  out  1  update pulse to GA
- ctrl_ocupado_o  out  1  controller not able to accept a request
- erro_timeout_o  out  1  sticky timeout flag
- contador_atualizacoes_o  out  COUNT_WIDTH  number of completed updates

Behaviour:
- Clocking and reset: single clock clk; asynchronous active-low reset rst_n. On reset, all outputs are 0, the state is OCIOSO, and all counters are 0. Reset mid-operation aborts with no further pulses.
- States: OCIOSO, FONTE, GUARDA, ESP_READY, ESP_LIVRE, PRONTO, ERRO.
- OCIOSO:
  - start_i=1 → register fonte_endereco_i and go to FONTE.
  - LVV requests are ignored and never acked.
- FONTE: top_atualizar_fonte_o=1 for exactly one cycle, then GUARDA.
- PRONTO, priority order per cycle:
  1. start_i=1 → re-latch the address and go to FONTE. Pending requests are not acked.
  2. lvv_desativar_req_i=1 → lvv_desativar_ack_o=1 and desativar_o=1 in the same cycle, then GUARDA.
  3. lvv_atualizar_req_i=1 → lvv_atualizar_ack_o=1 and atualizar_o=1 in the same cycle, then GUARDA.
- GUARDA:
  - Holds for GUARD_CYCLES cycles.
  - After an update grant → ESP_READY; after a fonte or desativar grant → ESP_LIVRE.
- ESP_READY: waits for ga_atualizar_ready_i=1. The counter then increments, saturating at all-ones, and the state goes to ESP_LIVRE. A ready pulse already seen during GUARDA is latched and counts.
- ESP_LIVRE: ga_ocupado_i=0 → PRONTO, or OCIOSO if no source has been loaded since reset.
- Timeout:
  - An 8-bit minimum ($clog2(TIMEOUT_MAX+1)) timer clears on entry to GUARDA and counts in ESP_READY and ESP_LIVRE.
  - Timer reaching TIMEOUT_MAX → ERRO and erro_timeout_o=1.
  - ERRO issues no pulses or acks.
  - clear_erro_i → OCIOSO, erro_timeout_o=0, and the source-loaded flag clears.
- Output rules:
  - All pulses and acks are registered outputs, exactly one cycle, and mutually exclusive.
  - ctrl_ocupado_o = state not in {OCIOSO, PRONTO}.
  - ga_atualizar_ready_i outside ESP_READY/GUARDA is ignored.

Decomposition:
- Shared package: the state encoding (localparams for the 7 states) and default GUARD_CYCLES/TIMEOUT_MAX constants, since the top level and the LVV reuse them.
- One natural sub-module, `temporizador_espera`: the loadable guard/timeout counter with outputs `guarda_ok` and `estourou`.

Test Plan:
- Source load: reset; start_i=1 with fonte_endereco_i=5'd3 → top_atualizar_fonte_o pulses once, top_endereco_fonte_o=3. Hold ga_ocupado_i=1 for 4 cycles → state PRONTO 1 cycle after ocupado falls.
- Both requests in one cycle: lvv_desativar_req_i=1 and lvv_atualizar_req_i=1 in PRONTO → desativar ack/pulse first. After GA idle, the atualizar ack/pulse follows. Never both pulses in the same cycle.
- Update completion: update grant, ga_atualizar_ready_i pulse 2 cycles later, ocupado low at cycle 5 → contador_atualizacoes_o goes 0→1 and the state returns to PRONTO.
- Early ocupado: ga_ocupado_i=0 during the GUARDA window → no early exit. The next grant waits ≥GUARD_CYCLES cycles.
- Timeout: ga_ocupado_i stuck at 1 after a desativar grant → erro_timeout_o=1 at GUARD_CYCLES+200 cycles and no further acks. clear_erro_i → OCIOSO with the flag at 0.
- Reset and start precedence: rst_n low during ESP_READY → all outputs 0 asynchronously and the counter is 0. Separately, start_i together with a request in PRONTO → FONTE is taken and no ack is issued.
